// File: rtl/blocpu_stack_unit.sv
// blocpu_stack_unit -- hardware stack for the blocpu core.
//
// Purpose: a downward-growing stack of CPU_WIDTH-bit words kept in a
// single-port array. It supports byte PUSH/POP/PEEK and two-word CALL/RET
// for 2*CPU_WIDTH-bit return addresses. Single-word operations take one
// cycle. CALL and RET take two cycles (IDLE -> SECOND).
//
// Ports:
//   clock, in_reset          rising-edge clock; asynchronous active-high reset
//   in_op_valid/out_op_ready request handshake (ready only in IDLE)
//   in_op                    000 NOP 001 PUSH 010 POP 011 CALL 100 RET
//                            101 PEEK 110 CLEAR 111 illegal
//   in_data, in_addr         PUSH operand / CALL return address
//   in_drop                  extra entries discarded by RET
//   in_error_clear           clears the sticky error flag and code
//   out_data, out_addr       POP/PEEK result / RET result (held between pulses)
//   out_result_valid         one-cycle pulse when a result is presented
//   out_count, out_full, out_empty  occupancy
//   out_error, out_error_code       sticky error (01 ovf, 10 unf, 11 illegal)
//
// Build option: define BLOCPU_STACK_GUARD_EN to reject overflowing and
// underflowing operations. Without it the stack pointer wraps, storage is
// overwritten, and the count saturates.
module blocpu_stack_unit #(
  parameter int CPU_WIDTH = 8,
  parameter int DEPTH     = 16,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   in_reset,
  input  logic                   in_op_valid,
  output logic                   out_op_ready,
  input  logic [2:0]             in_op,
  input  logic [CPU_WIDTH-1:0]   in_data,
  input  logic [2*CPU_WIDTH-1:0] in_addr,
  input  logic [3:0]             in_drop,
  input  logic                   in_error_clear,
  output logic [CPU_WIDTH-1:0]   out_data,
  output logic [2*CPU_WIDTH-1:0] out_addr,
  output logic                   out_result_valid,
  output logic [PW:0]            out_count,
  output logic                   out_full,
  output logic                   out_empty,
  output logic                   out_error,
  output logic [1:0]             out_error_code
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_CALL  = 3'b011;
  localparam logic [2:0] OP_RET   = 3'b100;
  localparam logic [2:0] OP_PEEK  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  // Wide enough for count plus the largest RET discard (2 + 15).
  localparam int EW = PW + 6;

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_CALL = (PW+1)'(DEPTH - 2);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_TWO  = (PW+1)'(2);
  localparam logic [PW-1:0] SP_ONE   = PW'(1);
  localparam logic [PW-1:0] SP_TWO   = PW'(2);

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  logic [CPU_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [PW-1:0]          sp_q, sp_d;
  logic [PW:0]            count_q, count_d;
  logic [2:0]             op_q, op_d;
  logic [3:0]             drop_q, drop_d;
  logic [CPU_WIDTH-1:0]   lo_q;
  logic [CPU_WIDTH-1:0]   data_q;
  logic [2*CPU_WIDTH-1:0] addr_q;
  logic                   valid_q, valid_d;
  logic                   err_q;
  logic [1:0]             code_q;

  logic                 accept;
  logic                 mem_we;
  logic [PW-1:0]        mem_addr;
  logic [CPU_WIDTH-1:0] mem_wdata;
  logic                 load_data, load_lo_mem, load_lo_addr, load_addr;
  logic                 err_set;
  logic [1:0]           err_code_new;
  logic [EW-1:0]        count_ext, need_acc, need_sec;
  logic                 push_block, call_block, pop_block, ret_block;

  assign count_ext = EW'(count_q);
  assign need_acc  = EW'(in_drop) + EW'(2);
  assign need_sec  = EW'(drop_q) + EW'(2);

`ifdef BLOCPU_STACK_GUARD_EN
  assign push_block = (count_q == CNT_FULL);
  assign call_block = (count_q > CNT_CALL);
  assign pop_block  = (count_q == '0);
  assign ret_block  = (count_ext < need_acc);
`else
  assign push_block = 1'b0;
  assign call_block = 1'b0;
  assign pop_block  = 1'b0;
  assign ret_block  = 1'b0;
`endif

  // Ready is forced low while reset is asserted, not just after the edge.
  assign out_op_ready = (state_q == S_IDLE) && !in_reset;
  assign accept       = in_op_valid && out_op_ready;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    count_d      = count_q;
    op_d         = op_q;
    drop_d       = drop_q;
    valid_d      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = sp_q;
    mem_wdata    = in_data;
    load_data    = 1'b0;
    load_lo_mem  = 1'b0;
    load_lo_addr = 1'b0;
    load_addr    = 1'b0;
    err_set      = 1'b0;
    err_code_new = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = in_op;
          drop_d = in_drop;
          case (in_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (push_block) begin
                err_set = 1'b1; err_code_new = ERR_OVF;
              end else begin
                mem_we   = 1'b1;
                mem_addr = sp_q - SP_ONE;
                sp_d     = sp_q - SP_ONE;
                count_d  = (count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_ONE;
              end
            end
            OP_POP, OP_PEEK: begin
              if (pop_block) begin
                err_set = 1'b1; err_code_new = ERR_UNF;
              end else begin
                load_data = 1'b1;
                valid_d   = 1'b1;
                if (in_op == OP_POP) begin
                  sp_d    = sp_q + SP_ONE;
                  count_d = (count_q == '0) ? '0 : count_q - CNT_ONE;
                end
              end
            end
            OP_CALL: begin
              if (call_block) begin
                err_set = 1'b1; err_code_new = ERR_OVF;
              end else begin
                // High byte now; low byte is kept in lo_q for SECOND.
                mem_we       = 1'b1;
                mem_addr     = sp_q - SP_ONE;
                mem_wdata    = in_addr[2*CPU_WIDTH-1:CPU_WIDTH];
                load_lo_addr = 1'b1;
                state_d      = S_SECOND;
              end
            end
            OP_RET: begin
              if (ret_block) begin
                err_set = 1'b1; err_code_new = ERR_UNF;
              end else begin
                load_lo_mem = 1'b1;
                state_d     = S_SECOND;
              end
            end
            OP_CLEAR: begin
              sp_d    = '0;
              count_d = '0;
            end
            default: begin
              err_set = 1'b1; err_code_new = ERR_ILL;
            end
          endcase
        end
      end
      S_SECOND: begin
        state_d = S_IDLE;
        if (op_q == OP_CALL) begin
          mem_we    = 1'b1;
          mem_addr  = sp_q - SP_TWO;
          mem_wdata = lo_q;
          sp_d      = sp_q - SP_TWO;
          count_d   = (count_q >= CNT_CALL) ? CNT_FULL : count_q + CNT_TWO;
        end else begin
          mem_addr  = sp_q + SP_ONE;
          load_addr = 1'b1;
          valid_d   = 1'b1;
          sp_d      = PW'(EW'(sp_q) + need_sec);
          count_d   = (count_ext < need_sec) ? '0 : (PW+1)'(count_ext - need_sec);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage has no reset: contents survive reset and CLEAR.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      count_q <= '0;
      op_q    <= OP_NOP;
      drop_q  <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      op_q    <= op_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      if (load_data)         data_q <= mem[mem_addr];
      if (load_lo_mem)       lo_q   <= mem[mem_addr];
      else if (load_lo_addr) lo_q   <= in_addr[CPU_WIDTH-1:0];
      if (load_addr)         addr_q <= {mem[mem_addr], lo_q};
      // A new error takes priority over a simultaneous clear.
      if (err_set) begin
        err_q  <= 1'b1;
        code_q <= err_code_new;
      end else if (in_error_clear) begin
        err_q  <= 1'b0;
        code_q <= 2'b00;
      end
    end
  end

  assign out_data         = data_q;
  assign out_addr         = addr_q;
  assign out_result_valid = valid_q;
  assign out_count        = count_q;
  assign out_full         = (count_q == CNT_FULL);
  assign out_empty        = (count_q == '0);
  assign out_error        = err_q;
  assign out_error_code   = code_q;

endmodule

// File: tb/tb_blocpu_stack_unit.sv
// Testbench for blocpu_stack_unit: directed vector table, hand-written
// multi-cycle sequences and randomized operations checked against a
// behavioural stack model.
module tb_blocpu_stack_unit;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = 4;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_CALL  = 3'b011;
  localparam logic [2:0] OP_RET   = 3'b100;
  localparam logic [2:0] OP_PEEK  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           in_reset, in_op_valid, out_op_ready, in_error_clear;
  logic [2:0]     in_op;
  logic [W-1:0]   in_data, out_data;
  logic [2*W-1:0] in_addr, out_addr;
  logic [3:0]     in_drop;
  logic           out_result_valid, out_full, out_empty, out_error;
  logic [PW:0]    out_count;
  logic [1:0]     out_error_code;

  blocpu_stack_unit #(.CPU_WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .in_reset(in_reset), .in_op_valid(in_op_valid),
    .out_op_ready(out_op_ready), .in_op(in_op), .in_data(in_data),
    .in_addr(in_addr), .in_drop(in_drop), .in_error_clear(in_error_clear),
    .out_data(out_data), .out_addr(out_addr), .out_result_valid(out_result_valid),
    .out_count(out_count), .out_full(out_full), .out_empty(out_empty),
    .out_error(out_error), .out_error_code(out_error_code)
  );

`ifdef BLOCPU_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: a circular array with a top index, as the stack is defined.
  logic [7:0]  m_mem [D];
  int          m_sp, m_count;
  logic        m_err;
  logic [1:0]  m_code;
  logic [7:0]  m_data;
  logic [15:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(out_count), 32'(m_count));
    chk("full", 32'(out_full), 32'(m_count == D));
    chk("empty", 32'(out_empty), 32'(m_count == 0));
    chk("error", 32'(out_error), 32'(m_err));
    chk("error_code", 32'(out_error_code), 32'(m_code));
    chk("data_hold", 32'(out_data), 32'(m_data));
    chk("addr_hold", 32'(out_addr), 32'(m_addr));
  endtask

  task automatic exec(input logic [2:0] op, input logic [7:0] d, input logic [15:0] a,
                      input logic [3:0] dr, input logic clr,
                      output logic got_v, output logic [7:0] got_d, output logic [15:0] got_a);
    int exp_lat, exp_pk, lat, pk, npulse, n;
    logic ne;
    logic [1:0] nc;
    exp_lat = 1; exp_pk = 0; ne = 1'b0; nc = 2'b00;
    case (op)
      OP_PUSH: if (GUARD && m_count == D) begin ne = 1; nc = 2'b01; end
               else begin
                 m_sp = (m_sp + D - 1) % D; m_mem[m_sp] = d;
                 m_count = (m_count == D) ? D : m_count + 1;
               end
      OP_POP, OP_PEEK: if (GUARD && m_count == 0) begin ne = 1; nc = 2'b10; end
               else begin
                 m_data = m_mem[m_sp]; exp_pk = 1;
                 if (op == OP_POP) begin
                   m_sp = (m_sp + 1) % D;
                   m_count = (m_count == 0) ? 0 : m_count - 1;
                 end
               end
      OP_CALL: if (GUARD && m_count > D - 2) begin ne = 1; nc = 2'b01; end
               else begin
                 m_mem[(m_sp + D - 1) % D] = a[15:8];
                 m_mem[(m_sp + D - 2) % D] = a[7:0];
                 m_sp = (m_sp + D - 2) % D;
                 m_count = (m_count + 2 > D) ? D : m_count + 2;
                 exp_lat = 2;
               end
      OP_RET: begin
        n = 2 + int'(dr);
        if (GUARD && m_count < n) begin ne = 1; nc = 2'b10; end
        else begin
          m_addr = {m_mem[(m_sp + 1) % D], m_mem[m_sp]};
          m_sp = (m_sp + n) % D;
          m_count = (m_count < n) ? 0 : m_count - n;
          exp_lat = 2; exp_pk = 2;
        end
      end
      OP_CLEAR: begin m_sp = 0; m_count = 0; end
      OP_ILL: begin ne = 1; nc = 2'b11; end
      default: ;
    endcase
    if (ne) begin m_err = 1'b1; m_code = nc; end
    else if (clr) begin m_err = 1'b0; m_code = 2'b00; end

    @(negedge clock);
    chk("ready_idle", 32'(out_op_ready), 32'd1);
    in_op = op; in_data = d; in_addr = a; in_drop = dr;
    in_error_clear = clr; in_op_valid = 1'b1;
    @(posedge clock);
    #1;
    // Scramble operands after accept; during SECOND also offer an illegal op
    // that must be ignored because the unit is busy.
    in_error_clear = 1'b0;
    in_drop = 4'($urandom); in_data = 8'($urandom); in_addr = 16'($urandom);
    in_op = OP_ILL; in_op_valid = (exp_lat == 2);
    lat = 0; pk = 0; npulse = 0; got_v = 1'b0; got_d = out_data; got_a = out_addr;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (out_op_ready && lat == 0) lat = k;
      if (out_result_valid) begin
        npulse++; pk = k; got_v = 1'b1; got_d = out_data; got_a = out_addr;
      end
      in_op_valid = 1'b0;
    end
    chk("busy_cycles", 32'(lat), 32'(exp_lat));
    chk("pulse_count", 32'(npulse), (exp_pk != 0) ? 32'd1 : 32'd0);
    if (exp_pk != 0) chk("pulse_cycle", 32'(pk), 32'(exp_pk));
    check_state();
    $display("op=%0d data=%02h addr=%04h drop=%0d clr=%0d -> valid=%0d out_data=%02h out_addr=%04h count=%0d err=%0d code=%0d",
             op, d, a, dr, clr, got_v, got_d, got_a, out_count, out_error, out_error_code);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  d;
    logic [15:0] a;
    logic [3:0]  dr;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [15:0] exp_a;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    logic [7:0] gd;
    logic [15:0] ga;
    logic [2:0] rop;
    int r;

    tbl[0]  = '{OP_PUSH, 8'h11, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 1};
    tbl[1]  = '{OP_PUSH, 8'h22, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 2};
    tbl[2]  = '{OP_PUSH, 8'h33, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 3};
    tbl[3]  = '{OP_POP,  8'h00, 16'h0000, 4'd0, 1'b1, 8'h33, 16'h0000, 2};
    tbl[4]  = '{OP_POP,  8'h00, 16'h0000, 4'd0, 1'b1, 8'h22, 16'h0000, 1};
    tbl[5]  = '{OP_POP,  8'h00, 16'h0000, 4'd0, 1'b1, 8'h11, 16'h0000, 0};
    tbl[6]  = '{OP_CALL, 8'h00, 16'hBEEF, 4'd0, 1'b0, 8'h00, 16'h0000, 2};
    tbl[7]  = '{OP_PUSH, 8'h05, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 3};
    tbl[8]  = '{OP_POP,  8'h00, 16'h0000, 4'd0, 1'b1, 8'h05, 16'h0000, 2};
    tbl[9]  = '{OP_RET,  8'h00, 16'h0000, 4'd0, 1'b1, 8'h00, 16'hBEEF, 0};
    tbl[10] = '{OP_PUSH, 8'hAA, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 1};
    tbl[11] = '{OP_PUSH, 8'hBB, 16'h0000, 4'd0, 1'b0, 8'h00, 16'h0000, 2};
    tbl[12] = '{OP_CALL, 8'h00, 16'h1234, 4'd0, 1'b0, 8'h00, 16'h0000, 4};
    tbl[13] = '{OP_RET,  8'h00, 16'h0000, 4'd2, 1'b1, 8'h00, 16'h1234, 0};

    in_reset = 1'b1; in_op_valid = 1'b0; in_op = OP_NOP; in_data = '0;
    in_addr = '0; in_drop = '0; in_error_clear = 1'b0;
    m_sp = 0; m_count = 0; m_err = 1'b0; m_code = 2'b00; m_data = '0; m_addr = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(out_op_ready), 32'd0);
    chk("rst_valid", 32'(out_result_valid), 32'd0);
    check_state();
    in_reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(out_op_ready), 32'd1);

    // Give every storage slot a known value, then empty the stack.
    for (int i = 0; i < D; i++) exec(OP_PUSH, 8'(i * 7 + 3), 16'h0, 4'd0, 1'b0, v, gd, ga);
    exec(OP_CLEAR, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      exec(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].dr, 1'b0, v, gd, ga);
      chk("tbl_valid", 32'(v), 32'(tbl[i].exp_v));
      chk("tbl_count", 32'(out_count), 32'(tbl[i].exp_cnt));
      if (tbl[i].exp_v && tbl[i].op != OP_RET) chk("tbl_data", 32'(gd), 32'(tbl[i].exp_d));
      if (tbl[i].exp_v && tbl[i].op == OP_RET) chk("tbl_addr", 32'(ga), 32'(tbl[i].exp_a));
    end
    chk("tbl_empty", 32'(out_empty), 32'd1);

    // Fill past capacity.
    exec(OP_CLEAR, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
`ifdef BLOCPU_STACK_GUARD_EN
    for (int i = 0; i < 16; i++) exec(OP_PUSH, 8'(i), 16'h0, 4'd0, 1'b0, v, gd, ga);
    exec(OP_PUSH, 8'h99, 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("ovf_error", 32'(out_error), 32'd1);
    chk("ovf_code", 32'(out_error_code), 32'd1);
    chk("ovf_count", 32'(out_count), 32'd16);
    exec(OP_NOP, 8'h0, 16'h0, 4'd0, 1'b1, v, gd, ga);
    chk("ovf_cleared", 32'(out_error), 32'd0);
    exec(OP_POP, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("ovf_pop", 32'(gd), 32'h0F);
`else
    for (int i = 0; i < 17; i++) exec(OP_PUSH, 8'(i), 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("wrap_error", 32'(out_error), 32'd0);
    chk("wrap_count", 32'(out_count), 32'd16);
    exec(OP_POP, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("wrap_pop", 32'(gd), 32'h10);
`endif

    // Error clear, and new error winning over a simultaneous clear.
    exec(OP_ILL, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("ill_code", 32'(out_error_code), 32'd3);
    exec(OP_NOP, 8'h0, 16'h0, 4'd0, 1'b1, v, gd, ga);
    chk("clr_error", 32'(out_error), 32'd0);
    exec(OP_ILL, 8'h0, 16'h0, 4'd0, 1'b1, v, gd, ga);
    chk("err_wins", 32'(out_error), 32'd1);
    exec(OP_NOP, 8'h0, 16'h0, 4'd0, 1'b1, v, gd, ga);

    // Reset while CALL is in SECOND.
    exec(OP_CLEAR, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
    @(negedge clock);
    in_op = OP_CALL; in_addr = 16'hCAFE; in_op_valid = 1'b1;
    @(posedge clock);
    #1;
    in_op_valid = 1'b0;
    chk("call_second_busy", 32'(out_op_ready), 32'd0);
    #1 in_reset = 1'b1;
    #1;
    m_mem[(m_sp + D - 1) % D] = 8'hCA;
    m_sp = 0; m_count = 0; m_err = 1'b0; m_code = 2'b00; m_data = '0; m_addr = '0;
    chk("mid_rst_ready", 32'(out_op_ready), 32'd0);
    chk("mid_rst_valid", 32'(out_result_valid), 32'd0);
    check_state();
    @(negedge clock);
    in_reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", 32'(out_op_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_no_pulse", 32'(out_result_valid), 32'd0);
      chk("mid_rst_count", 32'(out_count), 32'd0);
    end
    exec(OP_ILL, 8'h0, 16'h0, 4'd0, 1'b0, v, gd, ga);
    chk("post_rst_ill_code", 32'(out_error_code), 32'd3);

    // Randomized operations against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 15);
      if (r <= 4)       rop = OP_PUSH;
      else if (r <= 7)  rop = OP_POP;
      else if (r == 8)  rop = OP_PEEK;
      else if (r <= 10) rop = OP_CALL;
      else if (r <= 12) rop = OP_RET;
      else if (r == 13) rop = ($urandom_range(0, 3) == 0) ? OP_CLEAR : OP_NOP;
      else if (r == 14) rop = OP_NOP;
      else              rop = OP_ILL;
      exec(rop, 8'($urandom), 16'($urandom), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), v, gd, ga);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
